car_warning_ctrl: RTL



---
 rtl/car_warning_pkg.sv | 21 ++
 rtl/sw_debounce.sv | 44 ++++
 rtl/car_warning_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/car_warning_pkg.sv
// Shared types and constants for the seat-belt/door warning sequencer.
// Holds the FSM state encoding, the safe reset levels of the debounced switches and the warning predicate.
package car_warning_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CH_ON     = 2'd1,
        CH_OFF    = 2'd2,
        LAMP_ONLY = 2'd3
    } warn_state_e;

    // Safe levels: door closed, belt buckled, ignition off -> no warning out of reset.
    localparam logic DOOR_RST_VAL = 1'b1;
    localparam logic BELT_RST_VAL = 1'b1;
    localparam logic IGN_RST_VAL  = 1'b0;

    function automatic logic warn_cond(input logic ign, input logic door, input logic belt);
        return ign & (~door | ~belt);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer for one raw switch.
// The debounced level only follows the synchronised sample after DEB_CYCLES disagreeing cycles in a row.
module sw_debounce #(
    parameter int   DEB_CYCLES = 4,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_deb
);

    localparam int             CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;

    // Synchroniser chain and debounce counter; any agreeing sample restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
            r_deb   <= RST_VAL;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                r_cnt <= {CW{1'b0}};
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/car_warning_ctrl.sv
// Seat-belt/door warning sequencer: debounced switches feed a chime burst FSM that falls back to lamp-only.
// Warning drops back to IDLE the cycle after the condition clears, from any state.
module car_warning_ctrl
    import car_warning_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int CHIME_ON     = 8,
    parameter int CHIME_OFF    = 8,
    parameter int CHIME_BURSTS = 6
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic                              DoorClose,
    input  logic                              Ignition,
    input  logic                              SeatBelt,
    output logic                              Chime,
    output logic                              Lamp,
    output logic                              Alarm,
    output logic [$clog2(CHIME_BURSTS+1)-1:0] BurstCnt
);

    localparam int             BW         = $clog2(CHIME_BURSTS + 1);
    localparam int             PH_MAX     = (CHIME_ON > CHIME_OFF) ? CHIME_ON : CHIME_OFF;
    localparam int             PW         = $clog2(PH_MAX + 1);
    localparam logic [PW-1:0]  ON_LAST    = PW'(CHIME_ON - 1);
    localparam logic [PW-1:0]  OFF_LAST   = PW'(CHIME_OFF - 1);
    localparam logic [BW-1:0]  BURST_LAST = BW'(CHIME_BURSTS);
    localparam logic [BW-1:0]  BURST_ONE  = BW'(1);

    logic          w_door_d;
    logic          w_ign_d;
    logic          w_belt_d;
    logic          w_warn;
    logic [1:0]    w_cause;
    logic          w_new_cause;
    warn_state_e   w_state_nxt;
    logic [PW-1:0] w_phase_nxt;
    logic [BW-1:0] w_burst_nxt;

    warn_state_e   r_state;
    logic [PW-1:0] r_phase;
    logic [BW-1:0] r_burst;
    logic [1:0]    r_cause_prev;
    logic          r_chime;
    logic          r_lamp;
    logic          r_alarm;

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(DOOR_RST_VAL)) u_deb_door (
        .i_clk (Clk),
        .i_rst (Rst),
        .i_raw (DoorClose),
        .o_deb (w_door_d)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(IGN_RST_VAL)) u_deb_ign (
        .i_clk (Clk),
        .i_rst (Rst),
        .i_raw (Ignition),
        .o_deb (w_ign_d)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(BELT_RST_VAL)) u_deb_belt (
        .i_clk (Clk),
        .i_rst (Rst),
        .i_raw (SeatBelt),
        .o_deb (w_belt_d)
    );

    assign w_warn      = warn_cond(w_ign_d, w_door_d, w_belt_d);
    assign w_cause     = {~w_door_d, ~w_belt_d} & {2{w_ign_d}};
    assign w_new_cause = |(w_cause & ~r_cause_prev);

    // Next-state, phase and burst counters; Warn=0 beats every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_burst_nxt = r_burst;
        case (r_state)
            IDLE: begin
                if (w_warn) begin
                    w_state_nxt = CH_ON;
                    w_phase_nxt = {PW{1'b0}};
                    w_burst_nxt = BURST_ONE;
                end else begin
                    w_phase_nxt = {PW{1'b0}};
                    w_burst_nxt = {BW{1'b0}};
                end
            end
            CH_ON: begin
                if (!w_warn) begin
                    w_state_nxt = IDLE;
                    w_phase_nxt = {PW{1'b0}};
                    w_burst_nxt = {BW{1'b0}};
                end else if (r_phase == ON_LAST) begin
                    w_state_nxt = CH_OFF;
                    w_phase_nxt = {PW{1'b0}};
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end
            CH_OFF: begin
                if (!w_warn) begin
                    w_state_nxt = IDLE;
                    w_phase_nxt = {PW{1'b0}};
                    w_burst_nxt = {BW{1'b0}};
                end else if (r_phase == OFF_LAST) begin
                    w_phase_nxt = {PW{1'b0}};
                    if (r_burst == BURST_LAST) begin
                        w_state_nxt = LAMP_ONLY;
                        w_burst_nxt = {BW{1'b0}};
                    end else begin
                        w_state_nxt = CH_ON;
                        w_burst_nxt = r_burst + BW'(1);
                    end
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end
            LAMP_ONLY: begin
                if (!w_warn) begin
                    w_state_nxt = IDLE;
                    w_phase_nxt = {PW{1'b0}};
                    w_burst_nxt = {BW{1'b0}};
                end else if (w_new_cause) begin
                    w_state_nxt = CH_ON;
                    w_phase_nxt = {PW{1'b0}};
                    w_burst_nxt = BURST_ONE;
                end else begin
                    w_phase_nxt = {PW{1'b0}};
                    w_burst_nxt = {BW{1'b0}};
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_phase_nxt = {PW{1'b0}};
                w_burst_nxt = {BW{1'b0}};
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so they track r_state exactly.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_phase      <= {PW{1'b0}};
            r_burst      <= {BW{1'b0}};
            r_cause_prev <= 2'b00;
            r_chime      <= 1'b0;
            r_lamp       <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_burst      <= w_burst_nxt;
            r_cause_prev <= w_cause;
            r_chime      <= (w_state_nxt == CH_ON);
            r_lamp       <= (w_state_nxt != IDLE);
            r_alarm      <= w_warn;
        end
    end

    assign Chime    = r_chime;
    assign Lamp     = r_lamp;
    assign Alarm    = r_alarm;
    assign BurstCnt = r_burst;

endmodule
